fea_fetch_ctrl: RTL
===================

# fea_fetch_ctrl

Consumer-side controller for the traffic feature extractor's feature-address queue, sitting on the DL-engine/RV-core side of the TFE interface. It pops one ready-flow address when the queue is non-empty, reads that flow's feature vector from feature memory word by word, and streams it to the inference engine with valid/ready backpressure. After the engine signals inference complete, it releases the flow slot with a one-cycle `free_one_flow` pulse.

## Interface
- `ADDR_W`, 12: width of the flow-slot address returned by the TFE queue.
- `DATA_W`, 32: feature memory word width.
- `WORDS`, 8: feature words per flow; power of two, ≥2. `WB = log2(WORDS)`.
- `ADDR_TIMEOUT`, 15: cycles to wait for `fea_addr_v` after a pop before abandoning it.

Ports:
- `clk` in 1: single clock, the TFE external-side clock.
- `rst` in 1: synchronous, active-high reset.
- `fea_empty` in 1: TFE feature queue empty.
- `fetch_addr_en` out 1: one-cycle pop request to the TFE queue.
- `fea_addr` in ADDR_W: popped flow slot.
- `fea_addr_v` in 1: `fea_addr` valid, one cycle.
- `mem_rd_en` out 1: feature memory read strobe.
- `mem_rd_addr` out ADDR_W+WB: `{slot, word_idx}`.
- `mem_rd_data` in DATA_W: read data, valid exactly 1 cycle after `mem_rd_en`.
- `vec_data` out DATA_W: feature word to the engine.
- `vec_valid` out 1; `vec_ready` in 1; `vec_last` out 1: marks word WORDS-1.
- `infer_done` in 1: one-cycle pulse; inference on the current flow finished.
- `free_one_flow` out 1: one-cycle release pulse to the TFE.
- `busy` out 1: state ≠ IDLE.
- `flow_cnt` out 16: flows completed; wraps at 16'hFFFF→0.
- `err_timeout` out 1: sticky; set on an address timeout, cleared only by `rst`.

## Operation
The FSM has the following states:
- **IDLE**: if `!fea_empty`, assert `fetch_addr_en` for this cycle only, then go to WAIT_ADDR. Never issue a second pop until the flow is freed.
- **WAIT_ADDR**: on `fea_addr_v`, latch `fea_addr` into `slot`, clear `rd_idx`/`out_idx`, go to STREAM. If `fea_addr_v` does not arrive within ADDR_TIMEOUT cycles, set `err_timeout` and return to IDLE without freeing anything.
- **STREAM**: issue reads at `{slot, rd_idx}`. A read may issue only when `fifo_count + inflight < 2`. Read data is pushed into a 2-entry FIFO whose head drives `vec_data`/`vec_valid`. `vec_last = vec_valid && out_idx == WORDS-1`. When the handshake completes on the last word, go to WAIT_DONE. After WORDS reads, `mem_rd_en` stays low.
- **WAIT_DONE**: wait for `infer_done`, then go to FREE. `infer_done` in any other state is ignored.
- **FREE**: assert `free_one_flow` for one cycle, increment `flow_cnt`, go to IDLE.

Boundary conditions:
- Words are delivered in order 0..WORDS-1, with none dropped or duplicated under any `vec_ready` pattern.
- A simultaneous pop and push on the FIFO is legal when it is full.
- `fea_addr_v` outside WAIT_ADDR is ignored.

## Timing
- Reset: all outputs 0, state IDLE, FIFO flushed, and any in-flight read discarded. Reset mid-flow issues no `free_one_flow`.
- Pop latency: `fetch_addr_en` is high in the first cycle IDLE sees `!fea_empty`. It depends combinationally only on state and `fea_empty`.
- Cycle S+0 is the first STREAM cycle. The first `mem_rd_en` occurs at S+0, and `vec_valid` rises at S+2 (registered FIFO output).
- With `vec_ready` held high, one word per cycle. The last word handshakes at S+WORDS+1.
- `free_one_flow` rises one cycle after `infer_done` is sampled in WAIT_DONE. The earliest next `fetch_addr_en` is the cycle after that.
- `vec_data` and `vec_last` must stay stable while `vec_valid && !vec_ready`.

## Structure
- Shared package `fea_fetch_pkg`: FSM state enum, default parameter constants, and the `{slot, word_idx}` address packing function.
- One sub-module, `fea_skid_fifo`: 2-entry FIFO with count, parameterised on DATA_W and carrying an index field alongside the data.
- Everything else lives in `fea_fetch_ctrl`.

## Test plan
- **Basic flow, WORDS=8.** Stimulus: `fea_empty` falls, `fea_addr=12'h05A` one cycle after the pop, memory word = address, `vec_ready` held high. Required: reads at 0x2D0–0x2D7, data out 0x2D0..0x2D7, `vec_last` on 0x2D7, no free until `infer_done`. Then `infer_done` gives `free_one_flow` 1 cycle later and `flow_cnt=1`.
- **Backpressure.** Stimulus: `vec_ready` toggles 1010…, with 3 random stall bursts. Required: all 8 words in order, no duplicates, `vec_data` stable during stalls, at most 2 reads outstanding.
- **Timeout.** Stimulus: pop issued, `fea_addr_v` never arrives. Required: after 15 cycles, `err_timeout=1`, state IDLE, `free_one_flow` never pulses, and the next pop proceeds normally.
- **Reset mid-STREAM.** Stimulus: assert `rst` after 3 words. Required: all outputs 0 the next cycle, and no free. A fresh flow afterwards streams words 0..7 cleanly.
- **Spurious inputs and counter wrap.** Stimulus: `infer_done` pulsed in IDLE/STREAM, `fea_addr_v` pulsed in IDLE, and `flow_cnt` preloaded (via force) to 16'hFFFF before one flow completes. Required: the spurious pulses are ignored, and `flow_cnt` wraps to 0.

Source files
------------

// File: rtl/fea_fetch_pkg.sv
// Shared types and helpers for the feature-fetch controller.
package fea_fetch_pkg;

  localparam int unsigned DEF_ADDR_W       = 12;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_WORDS        = 8;
  localparam int unsigned DEF_ADDR_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_STREAM    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FREE      = 3'd4
  } fetch_state_t;

  // Feature memory address is the flow slot with the word index appended below it.
  function automatic logic [31:0] pack_rd_addr(input logic [31:0] slot,
                                               input logic [31:0] word_idx,
                                               input int unsigned wb);
    return (slot << wb) | word_idx;
  endfunction

endpackage

// File: rtl/fea_skid_fifo.sv
// Two-entry FIFO between feature memory read data and the engine stream.
// Each entry carries the word index so the consumer can tag the last word.
module fea_skid_fifo
  import fea_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic [IDX_W-1:0]  i_push_idx,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head_data,
  output logic [IDX_W-1:0]  o_head_idx,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_data [2];
  logic [IDX_W-1:0]  r_idx  [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Pop on empty is a no-op; push on full is accepted only alongside a pop.
  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // Entry storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_idx[i]  <= '0;
      end
    end else if (w_do_push) begin
      r_data[r_wr_ptr] <= i_push_data;
      r_idx[r_wr_ptr]  <= i_push_idx;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid     = (r_count != 2'd0);
  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_idx  = r_idx[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/fea_fetch_ctrl.sv
// Consumer-side controller for the TFE feature-address queue: pops one flow,
// streams its feature vector to the inference engine, then frees the slot.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no flow held; pop the queue as soon as it is non-empty
// WAIT_ADDR | pop issued; waiting (bounded) for the slot address
// STREAM    | reading feature words and handing them to the engine
// WAIT_DONE | all words delivered; waiting for inference complete
// FREE      | one-cycle release of the flow slot back to the TFE
module fea_fetch_ctrl
  import fea_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned WORDS        = DEF_WORDS,
  parameter int unsigned ADDR_TIMEOUT = DEF_ADDR_TIMEOUT
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_fea_empty,
  output logic                               o_fetch_addr_en,
  input  logic [ADDR_W-1:0]                  i_fea_addr,
  input  logic                               i_fea_addr_v,
  output logic                               o_mem_rd_en,
  output logic [ADDR_W+$clog2(WORDS)-1:0]    o_mem_rd_addr,
  input  logic [DATA_W-1:0]                  i_mem_rd_data,
  output logic [DATA_W-1:0]                  o_vec_data,
  output logic                               o_vec_valid,
  input  logic                               i_vec_ready,
  output logic                               o_vec_last,
  input  logic                               i_infer_done,
  output logic                               o_free_one_flow,
  output logic                               o_busy,
  output logic [15:0]                        o_flow_cnt,
  output logic                               o_err_timeout
);

  localparam int unsigned WB    = $clog2(WORDS);
  localparam int unsigned TMR_W = $clog2(ADDR_TIMEOUT + 1);

  localparam logic [WB-1:0]    LAST_IDX  = WB'(WORDS - 1);
  localparam logic [WB:0]      WORDS_CNT = (WB + 1)'(WORDS);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(ADDR_TIMEOUT - 1);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;

  logic [ADDR_W-1:0] r_slot;
  logic [WB:0]       r_rd_cnt;
  logic              r_rd_pend;
  logic [WB-1:0]     r_rd_pend_idx;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_err;
  logic [15:0]       r_flow_cnt;

  logic              w_fetch;
  logic              w_load_slot;
  logic              w_tmr_expire;
  logic              w_free;
  logic              w_rd_issue;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [DATA_W-1:0] w_fifo_data;
  logic [WB-1:0]     w_fifo_idx;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_occ;
  logic [2:0]        w_limit;

  fea_skid_fifo #(
    .DATA_W (DATA_W),
    .IDX_W  (WB)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_rd_pend),
    .i_push_data (i_mem_rd_data),
    .i_push_idx  (r_rd_pend_idx),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_head_data (w_fifo_data),
    .o_head_idx  (w_fifo_idx),
    .o_count     (w_fifo_count)
  );

  assign w_pop = w_fifo_valid && i_vec_ready;

  // Reads in flight plus buffered words never exceed the two FIFO entries.
  // A word leaving this cycle frees its entry for the read issued now, which
  // is what sustains one word per cycle with the engine always ready.
  assign w_occ      = {1'b0, w_fifo_count} + {2'b00, r_rd_pend};
  assign w_limit    = 3'd2 + {2'b00, w_pop};
  assign w_rd_issue = (r_state == ST_STREAM) && (r_rd_cnt != WORDS_CNT) && (w_occ < w_limit);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_fetch      = 1'b0;
    w_load_slot  = 1'b0;
    w_tmr_expire = 1'b0;
    w_free       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_fea_empty) begin
          w_fetch     = 1'b1;
          w_state_nxt = ST_WAIT_ADDR;
        end
      end
      ST_WAIT_ADDR: begin
        if (i_fea_addr_v) begin
          w_load_slot = 1'b1;
          w_state_nxt = ST_STREAM;
        end else if (r_tmr == '0) begin
          w_tmr_expire = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_pop && (w_fifo_idx == LAST_IDX)) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_infer_done) w_state_nxt = ST_FREE;
      end
      ST_FREE: begin
        w_free      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address-wait timer: counts down the cycles left in WAIT_ADDR.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                           r_tmr <= '0;
    else if (w_fetch)                                    r_tmr <= TMR_LOAD;
    else if ((r_state == ST_WAIT_ADDR) && (r_tmr != '0)) r_tmr <= r_tmr - 1'b1;
  end

  // Slot capture, read counter and the one-cycle read-latency tracker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot        <= '0;
      r_rd_cnt      <= '0;
      r_rd_pend     <= 1'b0;
      r_rd_pend_idx <= '0;
    end else begin
      if (w_load_slot) begin
        r_slot   <= i_fea_addr;
        r_rd_cnt <= '0;
      end else if (w_rd_issue) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      r_rd_pend     <= w_rd_issue;
      r_rd_pend_idx <= r_rd_cnt[WB-1:0];
    end
  end

  // Sticky timeout flag and completed-flow counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err      <= 1'b0;
      r_flow_cnt <= '0;
    end else begin
      if (w_tmr_expire) r_err <= 1'b1;
      if (w_free)       r_flow_cnt <= r_flow_cnt + 16'd1;
    end
  end

  assign o_fetch_addr_en = w_fetch;
  assign o_mem_rd_en     = w_rd_issue;
  assign o_mem_rd_addr   = (ADDR_W + WB)'(pack_rd_addr(32'(r_slot), 32'(r_rd_cnt[WB-1:0]), WB));
  assign o_vec_valid     = w_fifo_valid;
  assign o_vec_data      = w_fifo_valid ? w_fifo_data : '0;
  assign o_vec_last      = w_fifo_valid && (w_fifo_idx == LAST_IDX);
  assign o_free_one_flow = w_free;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_flow_cnt      = r_flow_cnt;
  assign o_err_timeout   = r_err;

endmodule
